// File: rtl/sp_pkg.sv
// sp_pkg: shared definitions for the stack-operation sequencer.
//   - sp_op_e     : op encodings on the op input
//   - sp_state_e  : sequencer FSM states
//   - SP_STACK_TOP / SP_STACK_LIMIT : default empty-stack SP and lowest legal address
//   - sp_word_count / sp_is_push    : per-op 16-bit word count and direction
package sp_pkg;

  localparam logic [31:0] SP_STACK_TOP   = 32'd2047;
  localparam logic [31:0] SP_STACK_LIMIT = 32'd1024;

  typedef enum logic [2:0] {
    OpNop  = 3'd0,
    OpPush = 3'd1,
    OpPop  = 3'd2,
    OpCall = 3'd3,
    OpRet  = 3'd4,
    OpInt  = 3'd5,
    OpRti  = 3'd6,
    OpRsvd = 3'd7
  } sp_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPush = 2'd1,
    StPop  = 2'd2,
    StDone = 2'd3
  } sp_state_e;

  // Number of 16-bit accesses an op needs; 0 means the op is ignored.
  function automatic logic [1:0] sp_word_count(input sp_op_e op);
    logic [1:0] cnt;
    case (op)
      OpPush, OpPop: cnt = 2'd1;
      OpCall, OpRet: cnt = 2'd2;
      OpInt,  OpRti: cnt = 2'd3;
      default:       cnt = 2'd0;
    endcase
    return cnt;
  endfunction

  function automatic logic sp_is_push(input sp_op_e op);
    return (op == OpPush) || (op == OpCall) || (op == OpInt);
  endfunction

endpackage

// File: rtl/sp_bounds_check.sv
// sp_bounds_check: combinational stack full/empty compare against the current SP.
// Ports:
//   i_sp     in  32  current stack pointer
//   o_full   out 1   a push at this SP would go below STACK_LIMIT
//   o_empty  out 1   a pop at this SP would go above the empty-stack SP
module sp_bounds_check
  import sp_pkg::*;
#(
  parameter logic [31:0] STACK_TOP   = SP_STACK_TOP,
  parameter logic [31:0] STACK_LIMIT = SP_STACK_LIMIT
) (
  input  logic [31:0] i_sp,
  output logic        o_full,
  output logic        o_empty
);

  assign o_full  = (i_sp < STACK_LIMIT);
  assign o_empty = (i_sp >= STACK_TOP);

endmodule

// File: rtl/sp_sequencer.sv
// sp_sequencer: splits PUSH/POP/CALL/RET/INT/RTI into one 16-bit stack access per cycle,
// driving data memory and the external SP register, and stalling until the op completes.
// Optional feature: define SP_BOUNDS_CHECK_EN to enable full/empty checking with stack_fault.
// Ports:
//   i_clk, i_rst_n (async, active-low)
//   i_op_valid, i_op[2:0], o_op_ready            op handshake (ready only in idle)
//   i_push_data[15:0], i_pc_in[31:0], i_flags_in[15:0]  op operands, latched on accept
//   i_sp_read_data[31:0], o_sp_write_data[31:0], o_sp_write_enable   SP register port
//   o_mem_addr[31:0], o_mem_wdata[15:0], o_mem_write, o_mem_read, i_mem_rdata[15:0]
//   o_stall, o_done, o_stack_fault              status (done/fault are one-cycle pulses)
//   o_pop_data[15:0], o_pc_out[31:0], o_flags_out[15:0]  pop results, held until next pop
module sp_sequencer
  import sp_pkg::*;
#(
  parameter logic [31:0] STACK_TOP   = SP_STACK_TOP,
  parameter logic [31:0] STACK_LIMIT = SP_STACK_LIMIT
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_op_valid,
  input  logic [2:0]  i_op,
  output logic        o_op_ready,
  input  logic [15:0] i_push_data,
  input  logic [31:0] i_pc_in,
  input  logic [15:0] i_flags_in,
  input  logic [31:0] i_sp_read_data,
  output logic [31:0] o_sp_write_data,
  output logic        o_sp_write_enable,
  output logic [31:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  output logic        o_mem_write,
  output logic        o_mem_read,
  input  logic [15:0] i_mem_rdata,
  output logic        o_stall,
  output logic        o_done,
  output logic [15:0] o_pop_data,
  output logic [31:0] o_pc_out,
  output logic [15:0] o_flags_out,
  output logic        o_stack_fault
);

  sp_state_e   r_state, w_state_d;
  sp_op_e      r_op, w_op_d;
  logic [31:0] r_pc, w_pc_d;
  logic [15:0] r_flags, w_flags_d;
  logic [15:0] r_push_data, w_push_data_d;
  logic [1:0]  r_cnt, w_cnt_d;
  logic [15:0] r_pop_data, w_pop_data_d;
  logic [31:0] r_pc_out, w_pc_out_d;
  logic [15:0] r_flags_out, w_flags_out_d;

  sp_op_e      w_op_in;
  logic [1:0]  w_cnt_load;
  logic [15:0] w_push_word;
  logic        w_full;
  logic        w_empty;
  logic        w_fault_set;

  assign w_op_in    = sp_op_e'(i_op);
  assign w_cnt_load = sp_word_count(w_op_in);

`ifdef SP_BOUNDS_CHECK_EN
  logic r_fault;

  sp_bounds_check #(
    .STACK_TOP   (STACK_TOP),
    .STACK_LIMIT (STACK_LIMIT)
  ) u_bounds_check (
    .i_sp    (i_sp_read_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Fault flag is cleared on every accept so it only reflects the op just completed.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_fault <= 1'b0;
    end else if (r_state == StIdle) begin
      r_fault <= 1'b0;
    end else if (w_fault_set) begin
      r_fault <= 1'b1;
    end
  end

  assign o_stack_fault = (r_state == StDone) && r_fault;
`else
  logic w_unused_params;

  assign w_full          = 1'b0;
  assign w_empty         = 1'b0;
  assign w_unused_params = ^{STACK_TOP, STACK_LIMIT, w_fault_set};
  assign o_stack_fault   = 1'b0;
`endif

  // Word order: CALL/INT push the PC high half first; INT appends flags last.
  always_comb begin
    w_push_word = r_push_data;
    case (r_op)
      OpCall: w_push_word = (r_cnt == 2'd2) ? r_pc[31:16] : r_pc[15:0];
      OpInt: begin
        case (r_cnt)
          2'd3:    w_push_word = r_pc[31:16];
          2'd2:    w_push_word = r_pc[15:0];
          default: w_push_word = r_flags;
        endcase
      end
      default: w_push_word = r_push_data;
    endcase
  end

  always_comb begin
    w_state_d         = r_state;
    w_op_d            = r_op;
    w_pc_d            = r_pc;
    w_flags_d         = r_flags;
    w_push_data_d     = r_push_data;
    w_cnt_d           = r_cnt;
    w_pop_data_d      = r_pop_data;
    w_pc_out_d        = r_pc_out;
    w_flags_out_d     = r_flags_out;
    w_fault_set       = 1'b0;
    o_sp_write_data   = 32'd0;
    o_sp_write_enable = 1'b0;
    o_mem_addr        = 32'd0;
    o_mem_wdata       = 16'd0;
    o_mem_write       = 1'b0;
    o_mem_read        = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_op_valid && (w_cnt_load != 2'd0)) begin
          w_op_d        = w_op_in;
          w_pc_d        = i_pc_in;
          w_flags_d     = i_flags_in;
          w_push_data_d = i_push_data;
          w_cnt_d       = w_cnt_load;
          w_state_d     = sp_is_push(w_op_in) ? StPush : StPop;
        end
      end

      StPush: begin
        if (w_full) begin
          // Abandon the remaining words; nothing is written this cycle.
          w_fault_set = 1'b1;
          w_state_d   = StDone;
        end else begin
          o_mem_addr        = i_sp_read_data;
          o_mem_wdata       = w_push_word;
          o_mem_write       = 1'b1;
          o_sp_write_data   = i_sp_read_data - 32'd1;
          o_sp_write_enable = 1'b1;
          w_cnt_d           = r_cnt - 2'd1;
          if (r_cnt == 2'd1) begin
            w_state_d = StDone;
          end
        end
      end

      StPop: begin
        if (w_empty) begin
          w_fault_set = 1'b1;
          w_state_d   = StDone;
        end else begin
          o_mem_addr        = i_sp_read_data + 32'd1;
          o_mem_read        = 1'b1;
          o_sp_write_data   = i_sp_read_data + 32'd1;
          o_sp_write_enable = 1'b1;
          w_cnt_d           = r_cnt - 2'd1;
          // RET/RTI pop in reverse push order: flags, PC low, PC high.
          case (r_op)
            OpRet, OpRti: begin
              case (r_cnt)
                2'd3:    w_flags_out_d      = i_mem_rdata;
                2'd2:    w_pc_out_d[15:0]   = i_mem_rdata;
                default: w_pc_out_d[31:16]  = i_mem_rdata;
              endcase
            end
            default: w_pop_data_d = i_mem_rdata;
          endcase
          if (r_cnt == 2'd1) begin
            w_state_d = StDone;
          end
        end
      end

      StDone: begin
        w_state_d = StIdle;
      end

      default: begin
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_op        <= OpNop;
      r_pc        <= 32'd0;
      r_flags     <= 16'd0;
      r_push_data <= 16'd0;
      r_cnt       <= 2'd0;
      r_pop_data  <= 16'd0;
      r_pc_out    <= 32'd0;
      r_flags_out <= 16'd0;
    end else begin
      r_state     <= w_state_d;
      r_op        <= w_op_d;
      r_pc        <= w_pc_d;
      r_flags     <= w_flags_d;
      r_push_data <= w_push_data_d;
      r_cnt       <= w_cnt_d;
      r_pop_data  <= w_pop_data_d;
      r_pc_out    <= w_pc_out_d;
      r_flags_out <= w_flags_out_d;
    end
  end

  assign o_op_ready  = (r_state == StIdle);
  assign o_stall     = (r_state != StIdle);
  assign o_done      = (r_state == StDone);
  assign o_pop_data  = r_pop_data;
  assign o_pc_out    = r_pc_out;
  assign o_flags_out = r_flags_out;

endmodule
